// File: rtl/adder_result_collector_if.sv
// Valid/ready result stream between the adder stage, the collector FIFO and its consumer.
// The collector uses the slave modport; the producer/consumer side uses master.
interface adder_result_collector_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_r;
  logic              in_c_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_r;
  logic              out_c_out;

  modport master (
    output in_valid, in_r, in_c_out, out_ready,
    input  in_ready, out_valid, out_r, out_c_out
  );

  modport slave (
    input  in_valid, in_r, in_c_out, out_ready,
    output in_ready, out_valid, out_r, out_c_out
  );
endinterface

// File: rtl/adder_result_collector.sv
// Result FIFO behind the three-operand adder with popped-result accumulation and carry counting.
// Optional sticky accumulator wrap flag acc_ovf when ADDER_COLLECTOR_OVF_FLAG_EN is defined.
//
// occupancy | meaning
// EMPTY     | count == 0, out_valid low, out_r/out_c_out forced to 0
// PARTIAL   | 0 < count < DEPTH, push and pop both possible
// FULL      | count == DEPTH, in_ready low, pushes held off even during a pop
module adder_result_collector #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ACC_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  adder_result_collector_if.slave    bus,
  input  logic                       clear,
  output logic [$clog2(DEPTH):0]     count,
  output logic [ACC_W-1:0]           acc_sum,
  output logic [7:0]                 carry_cnt
`ifdef ADDER_COLLECTOR_OVF_FLAG_EN
  ,
  output logic                       acc_ovf
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [DATA_W:0] entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] acc_sum_q, acc_sum_d;
  logic [7:0]       carry_cnt_q, carry_cnt_d;
`ifdef ADDER_COLLECTOR_OVF_FLAG_EN
  logic             acc_ovf_q, acc_ovf_d;
`endif

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  entry_t           head;
  logic [ACC_W-1:0] head_ext;
  logic [ACC_W-1:0] sum_next;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = bus.in_valid & ~full;
  assign pop   = bus.out_ready & ~empty;

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_r     = empty ? '0 : head[DATA_W-1:0];
  assign bus.out_c_out = ~empty & head[DATA_W];

  assign count     = count_q;
  assign acc_sum   = acc_sum_q;
  assign carry_cnt = carry_cnt_q;
`ifdef ADDER_COLLECTOR_OVF_FLAG_EN
  assign acc_ovf   = acc_ovf_q;
`endif

  // Accumulate from the gated outputs so an empty FIFO never feeds stale storage into the adder.
  always_comb begin
    head_ext           = '0;
    head_ext[DATA_W:0] = {bus.out_c_out, bus.out_r};
    sum_next           = acc_sum_q + head_ext;
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    acc_sum_d   = acc_sum_q;
    carry_cnt_d = carry_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_c_out, bus.in_r};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (clear) begin
      acc_sum_d   = '0;
      carry_cnt_d = '0;
    end else if (pop) begin
      acc_sum_d = sum_next;
      if (bus.out_c_out && (carry_cnt_q != 8'hFF)) begin
        carry_cnt_d = carry_cnt_q + 8'd1;
      end
    end
  end

`ifdef ADDER_COLLECTOR_OVF_FLAG_EN
  // A modular sum smaller than the old value means the addition carried out of ACC_W bits.
  always_comb begin
    acc_ovf_d = acc_ovf_q;
    if (clear) begin
      acc_ovf_d = 1'b0;
    end else if (pop && (sum_next < acc_sum_q)) begin
      acc_ovf_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      acc_sum_q   <= '0;
      carry_cnt_q <= '0;
`ifdef ADDER_COLLECTOR_OVF_FLAG_EN
      acc_ovf_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      acc_sum_q   <= acc_sum_d;
      carry_cnt_q <= carry_cnt_d;
`ifdef ADDER_COLLECTOR_OVF_FLAG_EN
      acc_ovf_q   <= acc_ovf_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_adder_result_collector.sv
// Scoreboard bench for adder_result_collector: queue-based reference model, randomized and directed traffic.
module tb_adder_result_collector;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [2:0]  count;
  logic [15:0] acc_sum;
  logic [7:0]  carry_cnt;
`ifdef ADDER_COLLECTOR_OVF_FLAG_EN
  logic        acc_ovf;
`endif

  adder_result_collector_if #(.DATA_W(8)) bus ();

  adder_result_collector #(.DATA_W(8), .DEPTH(DEPTH), .ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clear     (clear),
    .count     (count),
    .acc_sum   (acc_sum),
    .carry_cnt (carry_cnt)
`ifdef ADDER_COLLECTOR_OVF_FLAG_EN
    ,
    .acc_ovf   (acc_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted results plus plain integer accumulation.
  logic [8:0] mq[$];
  int         acc_m   = 0;
  int         cc_m    = 0;
  bit         ovf_m   = 0;
  bit         started = 0;
  int         pushes  = 0;
  int         pops    = 0;
  bit         do_push, do_pop;
  logic [8:0] popped;
  int         sum_m;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      acc_m   = 0;
      cc_m    = 0;
      ovf_m   = 0;
      started = 1;
    end else if (started) begin
      do_push = bus.in_valid && (mq.size() < DEPTH);
      do_pop  = bus.out_ready && (mq.size() != 0);
      if (do_pop) begin
        popped = mq.pop_front();
        pops++;
      end
      if (clear) begin
        acc_m = 0;
        cc_m  = 0;
        ovf_m = 0;
      end else if (do_pop) begin
        sum_m = acc_m + int'(popped);
        if (sum_m >= 65536) ovf_m = 1;
        acc_m = sum_m % 65536;
        if (popped[8] && cc_m < 255) cc_m++;
      end
      if (do_push) begin
        mq.push_back({bus.in_c_out, bus.in_r});
        pushes++;
      end
    end
  end

  // Monitor: mid-cycle comparison of every observable output against the model.
  always @(negedge clk) begin
    if (started) begin
      check("count", 32'(count), 32'(mq.size()));
      check("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
      check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("out_r", 32'(bus.out_r), 32'(mq[0][7:0]));
        check("out_c_out", 32'(bus.out_c_out), 32'(mq[0][8]));
      end else begin
        check("out_r_empty", 32'(bus.out_r), 32'd0);
        check("out_c_out_empty", 32'(bus.out_c_out), 32'd0);
      end
      check("acc_sum", 32'(acc_sum), 32'(acc_m));
      check("carry_cnt", 32'(carry_cnt), 32'(cc_m));
`ifdef ADDER_COLLECTOR_OVF_FLAG_EN
      check("acc_ovf", 32'(acc_ovf), 32'(ovf_m));
`endif
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input logic [7:0] r, input logic rdy);
    bus.in_valid  = v;
    bus.in_c_out  = c;
    bus.in_r      = r;
    bus.out_ready = rdy;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (DEPTH + 1) cycle();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int limit;
    rst   = 1'b1;
    clear = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset state
    repeat (2) cycle();
    rst = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_r", 32'(bus.out_r), 32'd0);
    check("rst_acc_sum", 32'(acc_sum), 32'd0);
    check("rst_carry_cnt", 32'(carry_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Two pushes, then two pops
    drive(1'b1, 1'b0, 8'h0F, 1'b0); cycle();
    drive(1'b1, 1'b1, 8'hF0, 1'b0); cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("two_push_count", 32'(count), 32'd2);
    check("two_push_head", 32'(bus.out_r), 32'h0F);
    bus.out_ready = 1'b1;
    repeat (2) cycle();
    bus.out_ready = 1'b0;
    check("two_pop_acc", 32'(acc_sum), 32'h01FF);
    check("two_pop_carry", 32'(carry_cnt), 32'd1);

    // Fill past full; fifth result is held until a slot frees
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i[0], 8'(8'h30 + i), 1'b0);
      cycle();
    end
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1; cycle();
    bus.out_ready = 1'b0;
    check("full_pop_count", 32'(count), 32'd3);
    cycle();
    bus.in_valid = 1'b0;
    check("held_accept_count", 32'(count), 32'd4);
    drain();

    // Steady push+pop at count=2 across pointer wrap
    drive(1'b1, 1'b0, 8'h51, 1'b0); cycle();
    drive(1'b1, 1'b1, 8'h52, 1'b0); cycle();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, i[1], 8'(8'h60 + i), 1'b1);
      cycle();
      check("pushpop_count", 32'(count), 32'd2);
    end
    drain();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(3, 0) != 0, 1'($urandom), 8'($urandom), $urandom_range(2, 0) != 0);
      clear = ($urandom_range(49, 0) == 0);
      cycle();
    end
    clear = 1'b0;
    drain();

    // 300 pops of {1,FF}: wraps the accumulator and saturates the carry count
    clear = 1'b1; cycle(); clear = 1'b0;
    pushes = 0;
    pops   = 0;
    limit  = 0;
    while (pops < 300 && limit < 2000) begin
      drive(pushes < 300, 1'b1, 8'hFF, 1'b1);
      cycle();
      limit++;
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("sat_pops_done", 32'(pops), 32'd300);
    check("sat_acc_sum", 32'(acc_sum), 32'h56D4);
    check("sat_carry_cnt", 32'(carry_cnt), 32'd255);
`ifdef ADDER_COLLECTOR_OVF_FLAG_EN
    check("sat_acc_ovf", 32'(acc_ovf), 32'd1);
`endif

    // Clear coincident with a pop
    drive(1'b1, 1'b0, 8'h05, 1'b0); cycle();
    drive(1'b1, 1'b1, 8'h11, 1'b0); cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    bus.out_ready = 1'b0;
    check("clear_acc_sum", 32'(acc_sum), 32'd0);
    check("clear_carry_cnt", 32'(carry_cnt), 32'd0);
    check("clear_count", 32'(count), 32'd1);
`ifdef ADDER_COLLECTOR_OVF_FLAG_EN
    check("clear_acc_ovf", 32'(acc_ovf), 32'd0);
`endif

    // Reset mid-stream at count=3
    drive(1'b1, 1'b0, 8'h77, 1'b0); cycle();
    drive(1'b1, 1'b1, 8'h78, 1'b0); cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_r", 32'(bus.out_r), 32'd0);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
